// File: rtl/bcd_updown_display.sv
// Multi-digit BCD up/down counter with a time-multiplexed active-low seven-segment driver.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bcd_updown_display #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  up,
  input  logic                  step,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] count_reg, count_next;
  logic                wrap_reg, wrap_next;
  logic [TW-1:0]       timer_reg, timer_next;
  logic [IW-1:0]       idx_reg, idx_next;
  logic [7:0]          seg_reg, seg_next;
  logic [DIGITS-1:0]   an_reg, an_next;

  logic [3:0]          digit [DIGITS];
  logic [DIGITS-1:0]   at_nine, at_zero, carry_up, borrow_dn, blank_mask;
  logic [4*DIGITS-1:0] inc_val, dec_val, load_clean;

  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Per-digit carry/borrow uses a flat AND of lower digits rather than a ripple chain.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit[gi]   = count_reg[gi*4 +: 4];
      assign at_nine[gi] = (digit[gi] == 4'd9);
      assign at_zero[gi] = (digit[gi] == 4'd0);

      if (gi == 0) begin : g_lsd
        assign carry_up[gi]  = 1'b1;
        assign borrow_dn[gi] = 1'b1;
      end else begin : g_upper
        assign carry_up[gi]  = &at_nine[gi-1:0];
        assign borrow_dn[gi] = &at_zero[gi-1:0];
      end

      assign inc_val[gi*4 +: 4] = !carry_up[gi] ? digit[gi] :
                                  (at_nine[gi] ? 4'd0 : digit[gi] + 4'd1);
      assign dec_val[gi*4 +: 4] = !borrow_dn[gi] ? digit[gi] :
                                  (at_zero[gi] ? 4'd9 : digit[gi] - 4'd1);
      assign load_clean[gi*4 +: 4] = (load_val[gi*4 +: 4] > 4'd9) ? 4'd0
                                                                   : load_val[gi*4 +: 4];

`ifdef LEADING_ZERO_BLANK_EN
      if (gi == 0) begin : g_noblank
        assign blank_mask[gi] = 1'b0;
      end else begin : g_blank
        assign blank_mask[gi] = &at_zero[DIGITS-1:gi];
      end
`else
      assign blank_mask[gi] = 1'b0;
`endif
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = load_clean;
    end else if (step) begin
      if (up) begin
        count_next = inc_val;
        wrap_next  = &at_nine;
      end else begin
        count_next = dec_val;
        wrap_next  = &at_zero;
      end
    end
  end

  always_comb begin
    timer_next = timer_reg + TW'(1);
    idx_next   = idx_reg;
    if (timer_reg == TW'(REFRESH_DIV - 1)) begin
      timer_next = '0;
      idx_next   = (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + IW'(1);
    end
  end

  // Display stage samples the live count, so seg trails count by one cycle.
  always_comb begin
    an_next  = ~(DIGITS'(1) << idx_reg);
    seg_next = blank_mask[idx_reg] ? 8'hFF : encode(digit[idx_reg]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      wrap_reg  <= 1'b0;
      timer_reg <= '0;
      idx_reg   <= '0;
      seg_reg   <= 8'hFF;
      an_reg    <= '1;
    end else begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
      timer_reg <= timer_next;
      idx_reg   <= idx_next;
      seg_reg   <= seg_next;
      an_reg    <= an_next;
    end
  end

  assign count = count_reg;
  assign wrap  = wrap_reg;
  assign seg   = seg_reg;
  assign an    = an_reg;

endmodule

// File: tb/tb_bcd_updown_display.sv
// Directed scoreboard bench for bcd_updown_display (DIGITS=4, REFRESH_DIV=3).
module tb_bcd_updown_display;

  localparam int DIGITS = 4;
  localparam int RDIV   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        up = 1'b1;
  logic        step = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] count;
  logic        wrap;
  logic [7:0]  seg;
  logic [3:0]  an;

  bcd_updown_display #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV)) dut (
    .clk(clk), .rst(rst), .up(up), .step(step), .load(load),
    .load_val(load_val), .count(count), .wrap(wrap), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cnt;
    logic        wrap;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   model = 0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] lv);
    int v;
    int m;
    logic [3:0] n;
    v = 0;
    m = 1;
    for (int i = 0; i < 4; i++) begin
      n = lv[i*4 +: 4];
      if (n <= 4'd9) v = v + int'(n) * m;
      m = m * 10;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic l, input logic s, input logic u,
                     input logic [15:0] v);
    exp_t e;
    logic w;
    w = 1'b0;
    @(negedge clk);
    load = l; step = s; up = u; load_val = v;
    if (l) begin
      model = from_load(v);
    end else if (s) begin
      if (u) begin
        w = (model == 9999);
        model = (model + 1) % 10000;
      end else begin
        w = (model == 0);
        model = (model + 9999) % 10000;
      end
    end
    e.cnt = to_bcd(model);
    e.wrap = w;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    load = 1'b0;
    step = 1'b0;
    e = sb.pop_front();
    chk({e.tag, "_count"}, 32'(count), 32'(e.cnt));
    chk({e.tag, "_wrap"}, 32'(wrap), 32'(e.wrap));
    $display("txn %s load=%0b step=%0b up=%0b val=%h -> count=%h wrap=%0b",
             tag, l, s, u, v, count, wrap);
  endtask

  // segs holds the expected pattern for digit k in bits [k*8 +: 8].
  task automatic scan(input string tag, input logic [31:0] segs);
    logic [3:0] prev;
    logic [3:0] ea;
    logic [7:0] es;
    bit found;
    found = 1'b0;
    prev = an;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      #1;
      if (an == 4'b1110 && prev != 4'b1110) found = 1'b1;
      else prev = an;
    end
    total++;
    assert (found) else begin
      bad++;
      $error("FAIL %s_sync observed=no_anode0_entry expected=anode0_entry", tag);
    end
    if (found) begin
      for (int k = 0; k < DIGITS * RDIV; k++) begin
        if (k > 0) begin
          @(posedge clk);
          #1;
        end
        ea = ~(4'b0001 << (k / RDIV));
        es = segs[(k / RDIV) * 8 +: 8];
        chk({tag, "_an"}, 32'(an), 32'(ea));
        chk({tag, "_seg"}, 32'(seg), 32'(es));
      end
      $display("txn %s scan of %0d cycles checked", tag, DIGITS * RDIV);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] blank_exp;

    // Reset held while requests are applied.
    rst = 1'b0; load = 1'b1; step = 1'b1; load_val = 16'h1234;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_an", 32'(an), 32'hF);
    $display("txn reset_hold count=%h seg=%h an=%b", count, seg, an);

    @(negedge clk);
    rst = 1'b1; load = 1'b0; step = 1'b0;
    model = 0;
    @(posedge clk);
    #1;
    chk("rel_an", 32'(an), 32'hE);
    chk("rel_seg", 32'(seg), 32'hC0);
    chk("rel_count", 32'(count), 32'h0);
    $display("txn reset_release an=%b seg=%h", an, seg);

    cyc("ld9999", 1'b1, 1'b0, 1'b1, 16'h9999);
    cyc("inc_wrap", 1'b0, 1'b1, 1'b1, 16'h0000);
    cyc("inc_one", 1'b0, 1'b1, 1'b1, 16'h0000);
    cyc("ld1000", 1'b1, 1'b0, 1'b0, 16'h1000);
    cyc("dec_borrow", 1'b0, 1'b1, 1'b0, 16'h0000);
    cyc("ld0000", 1'b1, 1'b0, 1'b0, 16'h0000);
    cyc("dec_wrap", 1'b0, 1'b1, 1'b0, 16'h0000);
    cyc("hold", 1'b0, 1'b0, 1'b0, 16'h0000);
    cyc("ld_prio", 1'b1, 1'b1, 1'b1, 16'h12F4);
    cyc("inc_b2b1", 1'b0, 1'b1, 1'b1, 16'h0000);
    cyc("inc_b2b2", 1'b0, 1'b1, 1'b1, 16'h0000);
    cyc("inc_b2b3", 1'b0, 1'b1, 1'b1, 16'h0000);
    cyc("ld_0199", 1'b1, 1'b0, 1'b1, 16'h0199);
    cyc("inc_carry", 1'b0, 1'b1, 1'b1, 16'h0000);

    cyc("ld1234", 1'b1, 1'b0, 1'b1, 16'h1234);
    scan("scan1234", {8'hF9, 8'hA4, 8'hB0, 8'h99});

    cyc("ld0050", 1'b1, 1'b0, 1'b1, 16'h0050);
`ifdef LEADING_ZERO_BLANK_EN
    blank_exp = {8'hFF, 8'hFF, 8'h92, 8'hC0};
`else
    blank_exp = {8'hC0, 8'hC0, 8'h92, 8'hC0};
`endif
    scan("scan0050", blank_exp);

    // Asynchronous reset mid-cycle, checked before any clock edge.
    cyc("ld5678", 1'b1, 1'b0, 1'b1, 16'h5678);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_seg", 32'(seg), 32'hFF);
    chk("arst_an", 32'(an), 32'hF);
    $display("txn async_reset count=%h seg=%h an=%b", count, seg, an);
    @(negedge clk);
    rst = 1'b1;
    model = 0;
    cyc("post_rst_dec", 1'b0, 1'b1, 1'b0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
